lut_m_ctrl: RTL and testbench



---
 rtl/lut_ctrl_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/lut_m_ctrl.sv | 140 ++++++++++++++
 tb/tb_lut_m_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lut_ctrl_pkg.sv
// Shared types and sizing helpers for the LUT sequencing controller.
// No timing of its own; consumed at elaboration.
// No flow control; pure declarations.
package lut_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_WRITE  = 2'd3
    } ctrl_state_t;

    // Number of config words needed to fill the LUT shadow register.
    function automatic int calc_nwords(input int mem_size, input int cfg_width);
        return mem_size / cfg_width;
    endfunction

    // Word counter width; must be able to hold NWORDS itself.
    function automatic int calc_cnt_width(input int nwords);
        return (nwords < 1) ? 1 : $clog2(nwords + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last winner.
// Grant is combinational from req; pointer moves on the cycle grant_en is high.
// Unrequested slots are skipped; the pointer holds while no grant is taken.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         grant_en,
    output logic [N-1:0] grant
);

    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] win_idx;

    // Scan from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        grant   = '0;
        win_idx = ptr;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant                         = '0;
                grant[(int'(ptr) + k) % N]    = 1'b1;
                win_idx                       = IDXW'((int'(ptr) + k) % N);
            end
        end
    end

    // Pointer starts at the last slot so requester 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDXW'(N - 1);
        end else if (grant_en && (|grant)) begin
            ptr <= win_idx;
        end
    end

endmodule

// File: rtl/lut_m_ctrl.sv
// Sequences block config loads and arbitrated single-bit writes into one LUT.
// Write: accepted cycle N -> lut_write_en cycle N+1; last config word N -> lut_cen N+1.
// cfg_ready/req_ready are combinational; config outranks user writes in IDLE.
module lut_m_ctrl
    import lut_ctrl_pkg::*;
#(
    parameter int INPUTS       = 4,
    parameter int MEM_SIZE     = 2 ** INPUTS,
    parameter int CONFIG_WIDTH = 8,
    parameter int NUM_REQ      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    input  logic [CONFIG_WIDTH-1:0]     cfg_data,
    output logic                        cfg_ready,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*INPUTS-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]          req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [INPUTS-1:0]           rd_addr,
    output logic                        rd_stall,
    output logic [INPUTS-1:0]           lut_addr,
    output logic                        lut_data_in,
    output logic                        lut_write_en,
    output logic                        lut_cen,
    output logic [MEM_SIZE-1:0]         lut_config,
    output logic                        busy
);

    localparam int NWORDS = calc_nwords(MEM_SIZE, CONFIG_WIDTH);
    localparam int CNTW   = calc_cnt_width(NWORDS);
    localparam logic [CNTW-1:0] LAST_WORD = CNTW'(NWORDS - 1);

    generate
        if ((MEM_SIZE % CONFIG_WIDTH) != 0 || NUM_REQ < 1) begin : g_param_check
            $error("lut_m_ctrl: MEM_SIZE must be a multiple of CONFIG_WIDTH and NUM_REQ >= 1");
        end
    endgenerate

    ctrl_state_t          state;
    logic [MEM_SIZE-1:0]  shadow;
    logic [CNTW-1:0]      count;
    logic [INPUTS-1:0]    wr_addr;
    logic                 wr_data;

    logic [NUM_REQ-1:0]   arb_grant;
    logic                 grant_en;
    logic [INPUTS-1:0]    sel_addr;
    logic                 sel_data;
    logic                 in_idle;
    logic                 wr_active;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .grant_en (grant_en),
        .grant    (arb_grant)
    );

    assign in_idle   = (state == ST_IDLE);
    assign cfg_ready = ~rst & ((state == ST_IDLE) | (state == ST_LOAD));
    // A pending config word blocks every user grant in IDLE.
    assign req_ready = (~rst & in_idle & ~cfg_valid) ? arb_grant : '0;
    assign grant_en  = |req_ready;

    // Write-phase outputs are suppressed in a reset cycle.
    assign wr_active    = ~rst & (state == ST_WRITE);
    assign lut_write_en = wr_active;
    assign rd_stall     = wr_active;
    assign lut_addr     = wr_active ? wr_addr : rd_addr;
    assign lut_data_in  = wr_active & wr_data;
    assign lut_cen      = ~rst & (state == ST_COMMIT);
    assign lut_config   = shadow;
    assign busy         = ~in_idle;

    // Pick out the address/bit of whichever requester holds the grant.
    always_comb begin
        sel_addr = '0;
        sel_data = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr = req_addr[i*INPUTS +: INPUTS];
                sel_data = req_data[i];
            end
        end
    end

    // Controller FSM: config word assembly, commit pulse, and single-bit writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shadow  <= '0;
            count   <= '0;
            wr_addr <= '0;
            wr_data <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        shadow[0 +: CONFIG_WIDTH] <= cfg_data;
                        count <= CNTW'(1);
                        state <= (NWORDS == 1) ? ST_COMMIT : ST_LOAD;
                    end else if (grant_en) begin
                        wr_addr <= sel_addr;
                        wr_data <= sel_data;
                        state   <= ST_WRITE;
                    end
                end
                ST_LOAD: begin
                    if (cfg_valid) begin
                        for (int k = 0; k < NWORDS; k++) begin
                            if (count == CNTW'(k)) begin
                                shadow[k*CONFIG_WIDTH +: CONFIG_WIDTH] <= cfg_data;
                            end
                        end
                        count <= count + 1'b1;
                        if (count == LAST_WORD) begin
                            state <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    count <= '0;
                    state <= ST_IDLE;
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_m_ctrl.sv
// Self-checking bench for lut_m_ctrl with default parameters.
// Every cycle is compared against a transaction-level model of the controller.
// Directed scenarios are followed by a randomized soak.
module tb_lut_m_ctrl;

    localparam int INPUTS = 4;
    localparam int MEM    = 16;
    localparam int CW     = 8;
    localparam int NR     = 2;
    localparam int NW     = MEM / CW;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic [CW-1:0]     cfg_data;
    logic              cfg_ready;
    logic [NR-1:0]     req_valid;
    logic [NR*INPUTS-1:0] req_addr;
    logic [NR-1:0]     req_data;
    logic [NR-1:0]     req_ready;
    logic [INPUTS-1:0] rd_addr;
    logic              rd_stall;
    logic [INPUTS-1:0] lut_addr;
    logic              lut_data_in;
    logic              lut_write_en;
    logic              lut_cen;
    logic [MEM-1:0]    lut_config;
    logic              busy;

    always #5 clk = ~clk;

    lut_m_ctrl #(
        .INPUTS       (INPUTS),
        .MEM_SIZE     (MEM),
        .CONFIG_WIDTH (CW),
        .NUM_REQ      (NR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_data     (cfg_data),
        .cfg_ready    (cfg_ready),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rd_addr      (rd_addr),
        .rd_stall     (rd_stall),
        .lut_addr     (lut_addr),
        .lut_data_in  (lut_data_in),
        .lut_write_en (lut_write_en),
        .lut_cen      (lut_cen),
        .lut_config   (lut_config),
        .busy         (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: words collected so far, pending one-cycle pulses, RR history.
    int              m_words;
    bit              m_commit;
    bit              m_write;
    logic [INPUTS-1:0] m_waddr;
    bit              m_wdata;
    int              m_last;
    logic [MEM-1:0]  m_shadow;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [NR-1:0] rv, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (rv[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    // Compare all outputs against the model, advance the model across the edge.
    task automatic tick();
        logic [NR-1:0] er;
        bit idle;
        bit wa;
        int g;
        #1;
        idle = !m_commit && !m_write && (m_words == 0);
        g    = model_pick(req_valid, m_last);
        er   = '0;
        if (!rst && idle && !cfg_valid && g >= 0) er[g] = 1'b1;
        wa = m_write && !rst;
        check("cfg_ready",    cfg_ready,    !rst && !m_commit && !m_write);
        check("req_ready",    req_ready,    er);
        check("lut_write_en", lut_write_en, wa);
        check("rd_stall",     rd_stall,     wa);
        check("lut_addr",     lut_addr,     wa ? m_waddr : rd_addr);
        check("lut_data_in",  lut_data_in,  wa && m_wdata);
        check("lut_cen",      lut_cen,      m_commit && !rst);
        check("lut_config",   lut_config,   m_shadow);
        check("busy",         busy,         !idle);
        if (rst) begin
            m_words = 0; m_commit = 0; m_write = 0; m_shadow = '0; m_last = NR - 1;
        end else if (m_commit) begin
            m_commit = 0;
        end else if (m_write) begin
            m_write = 0;
        end else if (cfg_valid) begin
            m_shadow[m_words*CW +: CW] = cfg_data;
            m_words++;
            if (m_words == NW) begin
                m_words  = 0;
                m_commit = 1;
            end
        end else if (idle && g >= 0) begin
            m_last  = g;
            m_waddr = req_addr[g*INPUTS +: INPUTS];
            m_wdata = req_data[g];
            m_write = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        int waited;
        logic [INPUTS-1:0] wq[$];

        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0;
        req_valid = '0; req_addr = '0; req_data = '0; rd_addr = '0;
        m_words = 0; m_commit = 0; m_write = 0; m_shadow = '0; m_last = NR - 1;
        m_waddr = '0; m_wdata = 0;
        @(negedge clk);

        // Reset, then two back-to-back config words.
        repeat (3) tick();
        rst = 1'b0;
        tick();
        cfg_valid = 1'b1; cfg_data = 8'hA5; tick();
        cfg_data = 8'h3C; tick();
        cfg_valid = 1'b0;
        check("cen_after_last_word", lut_cen, 1);
        check("config_3ca5", lut_config, 16'h3CA5);
        tick();
        check("busy_after_commit", busy, 0);
        tick();

        // Config with a bubble while requester 0 waits.
        req_addr = {4'd9, 4'd5}; req_data = 2'b01; req_valid = 2'b01;
        cfg_valid = 1'b1; cfg_data = 8'h11; tick();
        cfg_valid = 1'b0; repeat (3) tick();
        cfg_valid = 1'b1; cfg_data = 8'h22; tick();
        cfg_valid = 1'b0;
        waited = 0;
        while (!lut_write_en && waited < 10) begin
            tick();
            waited++;
        end
        check("bubble_write_seen",  lut_write_en, 1);
        check("bubble_write_delay", waited, 2);
        check("bubble_write_addr",  lut_addr, 5);

        // Both requesters held: grants alternate, writes every other cycle.
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (lut_write_en) wq.push_back(lut_addr);
        end
        check("rr_write_count", wq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("rr_write_addr", (i < wq.size()) ? wq[i] : 4'hx, (i % 2 == 0) ? 4'd9 : 4'd5);
        end
        req_valid = '0;
        tick();

        // Config and requester 1 together: config wins, pointer untouched.
        cfg_valid = 1'b1; cfg_data = 8'h77; req_valid = 2'b10;
        #1;
        check("simul_cfg_ready", cfg_ready, 1);
        check("simul_req_ready", req_ready, 2'b00);
        tick();
        cfg_valid = 1'b0; req_valid = 2'b11; tick();
        cfg_valid = 1'b1; cfg_data = 8'h88; tick();
        cfg_valid = 1'b0; tick();
        #1;
        check("ptr_kept_grant", req_ready, 2'b10);
        tick();
        req_valid = '0;
        tick();

        // Reset in the middle of a load discards it.
        cfg_valid = 1'b1; cfg_data = 8'h5A; tick();
        cfg_valid = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        check("rst_midload_config", lut_config, 16'h0000);
        check("rst_midload_busy", busy, 0);
        tick();
        cfg_valid = 1'b1; cfg_data = 8'h12; tick();
        cfg_data = 8'h34; tick();
        cfg_valid = 1'b0;
        check("reload_cen", lut_cen, 1);
        check("reload_config", lut_config, 16'h3412);
        tick();

        // Read address sweep while idle.
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            check("sweep_addr", lut_addr, i);
            check("sweep_stall", rd_stall, 0);
            tick();
        end

        // Randomized soak.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            cfg_valid = ($urandom_range(0, 9) < 3);
            cfg_data  = 8'($urandom);
            req_valid = 2'($urandom);
            req_addr  = 8'($urandom);
            req_data  = 2'($urandom);
            rd_addr   = 4'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
